load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage that sits directly downstream of the ALU. It takes the ALU result as the effective address and rs2 as store data. It then runs one data-memory transaction at a time over a request/ready/rvalid handshake, and returns aligned, sign/zero-extended load data to writeback. It stalls the pipeline while a transaction is outstanding and flags misaligned accesses instead of issuing them.

## Interface
- No parameters; address and data are fixed at 32 bits.
- Clock is `i_clk` and reset is `i_rst`. There is one clock, and reset is asynchronous and active-high.
- i_clk  in  1  clock
- i_rst  in  1  async active-high reset
- i_valid  in  1  one-cycle pulse: memory instruction present in this cycle
- i_load  in  1  instruction is a load (i_load and i_store are never both set)
- i_store  in  1  instruction is a store
- i_funct3  in  3  RV32I size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective address (ALU o_result)
- i_wdata  in  32  store data (rs2)
- o_busy  out  1  stall request to upstream
- o_done  out  1  one-cycle pulse: transaction complete
- o_rdata  out  32  extended load result; valid while o_done is high
- o_misaligned  out  1  one-cycle pulse: access rejected
- o_dmem_req  out  1  memory request
- o_dmem_we  out  1  write enable
- o_dmem_addr  out  32  word address ({i_addr[31:2], 2'b00})
- o_dmem_mask  out  4  byte-lane enables
- o_dmem_wdata  out  32  lane-replicated store data
- i_dmem_ready  in  1  memory accepts the request this cycle
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read data word

## Operation
- There are four states: IDLE, REQ, RESP and FIN.
- **Accept.** In IDLE, an access is accepted when i_valid is high and either i_load or i_store is high. On accept:
  - latch the address, funct3, load/store flag and wdata;
  - compute misalignment: H/HU with addr[0]=1, or W with addr[1:0]≠0.
- **Misaligned access.** The next cycle, o_misaligned pulses for one cycle and the state stays IDLE. No request is issued and o_done is not pulsed.
- **Aligned access.** The state goes to REQ.
- **REQ.** o_dmem_req is held high with stable addr, we, mask and wdata until i_dmem_ready is seen.
  - On ready for a store: go to FIN.
  - On ready for a load: go to RESP.
- **RESP.** Wait for i_dmem_rvalid. On rvalid, latch the extracted data and go to FIN. rvalid is ignored outside RESP.
- **FIN.** o_done is high for one cycle, then the state returns to IDLE.
- **o_busy** is high in REQ, RESP and FIN, i.e. whenever the state is not IDLE.
- **i_valid while busy.** i_valid is ignored whenever the state is not IDLE; upstream must not present an instruction then.
- **i_valid with neither load nor store** is ignored.
- **Mask:**
  - B/BU: 4'b0001 << addr[1:0]
  - H/HU: 4'b0011 << addr[1:0]
  - W: 4'b1111
- **Store data:**
  - B: {4{wdata[7:0]}}
  - H: {2{wdata[15:0]}}
  - W: wdata unchanged
- **Load extraction:** shift rdata right by 8·addr[1:0], take the low 8 or 16 bits (all 32 for W), then extend.
  - B and H sign-extend.
  - BU and HU zero-extend.
- **Unlisted funct3 codes** (011, 110, 111) behave as W.
- **o_dmem_we** equals the latched store flag. On a load, mask still reflects the access size.

## Timing
- **Reset values:** all outputs are 0 (o_busy, o_done, o_rdata, o_misaligned, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_mask, o_dmem_wdata). The state resets to IDLE.
- **Reset mid-transaction:** o_dmem_req drops immediately (asynchronously), with no o_done pulse.
- **Output timing:** all outputs are registered.
  - o_dmem_req rises the cycle after accept.
  - o_misaligned rises the cycle after accept.
- **Store with zero-wait memory** (ready in the first REQ cycle):
  - accept at cycle N, req at N+1, o_done at N+2.
  - The busy window is N+1..N+2.
- **Load with zero-wait memory** (ready at N+1, rvalid at N+2): o_done and o_rdata at N+3.
- **Memory ordering:** rvalid is never earlier than the cycle after ready.
- **Request hold:** once raised, o_dmem_req is deasserted only in the cycle after ready is seen.
- **o_rdata** holds its value after o_done until the next load completes.

## Structure
- Package `lsu_pkg` holds:
  - funct3 localparams: F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum: IDLE, REQ, RESP, FIN.
- Sub-module `load_align` (purely combinational): inputs rdata, addr[1:0] and funct3; output is the 32-bit extended result. It is instantiated once.

## Test plan
- **SB:** addr 0x1003, wdata 0x000000A5, ready at first REQ cycle → mask 4'b1000, wdata 0xA5A5A5A5, o_dmem_addr 0x1000, o_done 2 cycles after accept.
- **LB:** addr 0x2001, rdata 0x0000F000, ready in the first REQ cycle, rvalid 3 cycles later → o_rdata 0xFFFFFFF0.
- **LBU:** same stimulus as LB → o_rdata 0x000000F0.
- **LH:** addr 0x2001 → o_misaligned pulses once, no o_dmem_req, o_busy stays 0.
- **SW with wait states:** ready withheld for 4 cycles → req, addr and wdata stable for all 5 cycles; a second i_valid pulse during that time is ignored; o_done pulses exactly once.
- **Reset mid-load:** assert i_rst while in RESP → all outputs 0 immediately, no o_done; a new LW after reset completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared encodings and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP, FIN} lsu_state_t;

  // Unlisted funct3 codes fall through to word handling everywhere.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_B, F3_BU: return 1'b0;
      F3_H, F3_HU: return lo[0];
      default:     return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] lane_mask(input logic [2:0] funct3, input logic [1:0] lo);
    case (funct3)
      F3_B, F3_BU: return 4'b0001 << lo;
      F3_H, F3_HU: return 4'b0011 << lo;
      default:     return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [2:0] funct3, input logic [31:0] wdata);
    case (funct3)
      F3_B, F3_BU: return {4{wdata[7:0]}};
      F3_H, F3_HU: return {2{wdata[15:0]}};
      default:     return wdata;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/ready/rvalid bus between the LSU (master) and memory (slave).
interface load_store_unit_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  mask;
  logic [31:0] wdata;
  logic        ready;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, mask, wdata, input ready, rvalid, rdata);
  modport slave  (input req, we, addr, mask, wdata, output ready, rvalid, rdata);
endinterface

// File: rtl/load_align.sv
// Picks the addressed byte/half/word out of a read word and extends it.
module load_align
  import lsu_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [31:0] shifted;

  always_comb begin
    shifted = rdata >> {addr_lo, 3'b000};
    case (funct3)
      F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   result = {24'h0, shifted[7:0]};
      F3_HU:   result = {16'h0, shifted[15:0]};
      default: result = shifted;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-access stage: one outstanding data-memory transaction at a time,
// misaligned accesses are rejected instead of issued.
module load_store_unit
  import lsu_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_load,
  input  logic               i_store,
  input  logic [2:0]         i_funct3,
  input  logic [31:0]        i_addr,
  input  logic [31:0]        i_wdata,
  output logic               o_busy,
  output logic               o_done,
  output logic [31:0]        o_rdata,
  output logic               o_misaligned,
  load_store_unit_if.master  dmem
);

  lsu_state_t  state_q, state_d;
  logic        accept;
  logic        store_q;
  logic [1:0]  lo_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [3:0]  mask_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        misaligned_q;
  logic [31:0] aligned;

  assign accept = (state_q == IDLE) && i_valid && (i_load || i_store);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    o_busy   = 1'b0;
    o_done   = 1'b0;
    dmem.req = 1'b0;
    case (state_q)
      IDLE: if (accept && !is_misaligned(i_funct3, i_addr[1:0])) state_d = REQ;
      REQ: begin
        o_busy   = 1'b1;
        dmem.req = 1'b1;
        if (dmem.ready) state_d = store_q ? FIN : RESP;
      end
      RESP: begin
        o_busy = 1'b1;
        if (dmem.rvalid) state_d = FIN;
      end
      FIN: begin
        o_busy  = 1'b1;
        o_done  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  load_align u_align (
    .rdata   (dmem.rdata),
    .addr_lo (lo_q),
    .funct3  (funct3_q),
    .result  (aligned)
  );

  // Lane mask and replicated data are formed at accept so the bus is stable during REQ.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      store_q      <= 1'b0;
      lo_q         <= '0;
      funct3_q     <= '0;
      addr_q       <= '0;
      mask_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      misaligned_q <= accept && is_misaligned(i_funct3, i_addr[1:0]);
      if (accept) begin
        store_q  <= i_store;
        lo_q     <= i_addr[1:0];
        funct3_q <= i_funct3;
        addr_q   <= {i_addr[31:2], 2'b00};
        mask_q   <= lane_mask(i_funct3, i_addr[1:0]);
        wdata_q  <= lane_data(i_funct3, i_wdata);
      end
      if (state_q == RESP && dmem.rvalid) rdata_q <= aligned;
    end
  end

  assign o_rdata      = rdata_q;
  assign o_misaligned = misaligned_q;
  assign dmem.we      = store_q;
  assign dmem.addr    = addr_q;
  assign dmem.mask    = mask_q;
  assign dmem.wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized
// transactions checked against an arithmetic reference model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid, i_load, i_store;
  logic [2:0]  i_funct3;
  logic [31:0] i_addr, i_wdata;
  logic        o_busy, o_done, o_misaligned;
  logic [31:0] o_rdata;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  logic [31:0] last_rdata = '0;

  load_store_unit_if dmem ();

  load_store_unit dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_valid      (i_valid),
    .i_load       (i_load),
    .i_store      (i_store),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_rdata      (o_rdata),
    .o_misaligned (o_misaligned),
    .dmem         (dmem)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (o_done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, then plain arithmetic on it.
  function automatic int unsigned acc_bytes(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      default:        return 4;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input logic [31:0] a);
    return (a % acc_bytes(f3)) != 0;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
    int unsigned n = acc_bytes(f3);
    if (n == 4) return 32'hF;
    return (((32'd1 << n) - 1) << (a % 4)) & 32'hF;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    case (acc_bytes(f3))
      1:       return (w % 256) * 32'h01010101;
      2:       return (w % 65536) * 32'h00010001;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
    int unsigned n = acc_bytes(f3);
    longint v = longint'(rd >> (8 * (a % 4)));
    longint span = longint'(1) << (8 * n);
    bit sgn = (f3 == 3'b000) || (f3 == 3'b001);
    if (n < 4) begin
      v = v % span;
      if (sgn && v >= span / 2) v = v - span;
    end
    return v[31:0];
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_rdata"}, o_rdata, 0);
    check({tag, "_mis"}, o_misaligned, 0);
    check({tag, "_req"}, dmem.req, 0);
    check({tag, "_we"}, dmem.we, 0);
    check({tag, "_addr"}, dmem.addr, 0);
    check({tag, "_mask"}, dmem.mask, 0);
    check({tag, "_wdata"}, dmem.wdata, 0);
  endtask

  // Entered and left on a negedge. rdy_dly: REQ cycles before ready;
  // rv_dly: RESP cycles before rvalid; poke: pulse i_valid while busy.
  task automatic txn(input bit ld, input bit st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] w, input int rdy_dly, input int rv_dly,
                     input logic [31:0] rd, input bit poke);
    int d0;
    logic [31:0] exp_rd;
    check("idle_busy", o_busy, 0);
    i_valid = 1'b1; i_load = ld; i_store = st; i_funct3 = f3; i_addr = a; i_wdata = w;
    @(negedge clk);
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_addr = $urandom; i_wdata = $urandom;
    if (!(ld || st)) begin
      check("ign_req", dmem.req, 0);
      check("ign_busy", o_busy, 0);
      check("ign_mis", o_misaligned, 0);
      return;
    end
    if (ref_mis(f3, a)) begin
      check("mis_pulse", o_misaligned, 1);
      check("mis_req", dmem.req, 0);
      check("mis_busy", o_busy, 0);
      @(negedge clk);
      check("mis_end", o_misaligned, 0);
      check("mis_req2", dmem.req, 0);
      check("mis_busy2", o_busy, 0);
      return;
    end
    check("acc_mis", o_misaligned, 0);
    d0 = done_cnt;
    for (int k = 0; k <= rdy_dly; k++) begin
      check("req_hi", dmem.req, 1);
      check("req_busy", o_busy, 1);
      check("req_done", o_done, 0);
      check("req_we", dmem.we, st);
      check("req_addr", dmem.addr, a & 32'hFFFF_FFFC);
      check("req_mask", dmem.mask, ref_mask(f3, a));
      if (st) check("req_wdata", dmem.wdata, ref_wdata(f3, w));
      dmem.ready = (k == rdy_dly);
      if (poke && k == 0) begin
        i_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_4444;
      end
      @(negedge clk);
      dmem.ready = 1'b0;
      i_valid = 1'b0; i_load = 1'b0;
    end
    if (ld) begin
      for (int j = 0; j <= rv_dly; j++) begin
        check("resp_req", dmem.req, 0);
        check("resp_busy", o_busy, 1);
        check("resp_done", o_done, 0);
        dmem.rvalid = (j == rv_dly);
        dmem.rdata  = (j == rv_dly) ? rd : $urandom;
        @(negedge clk);
        dmem.rvalid = 1'b0;
        dmem.rdata  = $urandom;
      end
    end
    check("fin_done", o_done, 1);
    check("fin_busy", o_busy, 1);
    check("fin_req", dmem.req, 0);
    if (ld) begin
      exp_rd = ref_load(f3, a, rd);
      check("fin_rdata", o_rdata, exp_rd);
      last_rdata = exp_rd;
    end else begin
      check("hold_rdata", o_rdata, last_rdata);
    end
    @(negedge clk);
    check("post_done", o_done, 0);
    check("post_busy", o_busy, 0);
    check("done_once", done_cnt, d0 + 1);
    check("post_rdata", o_rdata, last_rdata);
  endtask

  logic [2:0] f3_tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

  initial begin
    int d0;
    rst = 1'b1;
    i_valid = 1'b0; i_load = 1'b0; i_store = 1'b0; i_funct3 = '0; i_addr = '0; i_wdata = '0;
    dmem.ready = 1'b0; dmem.rvalid = 1'b0; dmem.rdata = '0;
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // SB at byte 3, zero-wait memory
    txn(1'b0, 1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 0, 0, '0, 1'b0);
    // LB / LBU: ready immediately, rvalid three cycles after ready
    txn(1'b1, 1'b0, 3'b000, 32'h0000_2001, '0, 0, 2, 32'h0000_F000, 1'b0);
    check("lb_value", last_rdata, 32'hFFFF_FFF0);
    txn(1'b1, 1'b0, 3'b100, 32'h0000_2001, '0, 0, 2, 32'h0000_F000, 1'b0);
    check("lbu_value", last_rdata, 32'h0000_00F0);
    // LH misaligned
    txn(1'b1, 1'b0, 3'b001, 32'h0000_2001, '0, 0, 0, '0, 1'b0);
    // SW with four wait states and a stray i_valid while busy
    txn(1'b0, 1'b1, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 4, 0, '0, 1'b1);

    // Reset while waiting for rvalid
    i_valid = 1'b1; i_load = 1'b1; i_funct3 = 3'b010; i_addr = 32'h0000_5000;
    @(negedge clk);
    i_valid = 1'b0; i_load = 1'b0;
    dmem.ready = 1'b1;
    @(negedge clk);
    dmem.ready = 1'b0;
    check("pre_rst_busy", o_busy, 1);
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1 check_all_zero("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    last_rdata = '0;
    @(negedge clk);
    check("rst_no_done", done_cnt, d0);
    txn(1'b1, 1'b0, 3'b010, 32'h0000_6004, '0, 1, 1, 32'h1234_5678, 1'b0);

    for (int n = 0; n < 150; n++) begin
      int unsigned kind = $urandom % 8;
      logic [2:0] f3 = f3_tab[$urandom % 8];
      logic [31:0] a = $urandom;
      if ($urandom % 2) a = a & ~(acc_bytes(f3) - 1);
      txn(kind != 0 && kind < 5, kind >= 5, f3, a, $urandom,
          int'($urandom % 4), int'($urandom % 4), $urandom, ($urandom % 4) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
